// File: rtl/i2c_master_byte.sv
// Single-master I2C byte controller: START, address + R/W, address ACK, one
// data byte, data ACK, STOP, one transaction per start/done handshake.
module i2c_master_byte #(
  parameter int CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       rst_,
  input  logic       start,
  input  logic       rw,
  input  logic [6:0] addr,
  input  logic [7:0] wdata,
  input  logic       sda_in,
  output logic       busy,
  output logic       done,
  output logic       ack_err,
  output logic [7:0] rdata,
  output logic       scl_out,
  output logic       sda_out,
  output logic       sda_oe
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  typedef enum logic [2:0] {
    IDLE, START, ADDR, ADDR_ACK, DATA, DATA_ACK, STOP
  } state_t;

  state_t           state, state_nxt;
  logic [DIV_W-1:0] div_cnt;
  logic [1:0]       quarter;
  logic [2:0]       bit_cnt;
  logic             armed;
  logic [6:0]       addr_q;
  logic             rw_q;
  logic [7:0]       wdata_q;
  logic             sda_sample;
  logic [7:0]       addr_byte;
  logic             quarter_end, slot_end, sample_now, accept;

  assign quarter_end = (div_cnt == DIV_LAST);
  assign slot_end    = quarter_end && (quarter == 2'd3);
  assign sample_now  = quarter_end && (quarter == 2'd2);
  // armed blocks a start that coincides with the first edge after reset release
  assign accept      = (state == IDLE) && start && armed;
  assign busy        = (state != IDLE);
  assign addr_byte   = {addr_q, rw_q};

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:     if (accept) state_nxt = START;
      START:    if (slot_end) state_nxt = ADDR;
      ADDR:     if (slot_end && bit_cnt == 3'd7) state_nxt = ADDR_ACK;
      ADDR_ACK: if (slot_end) state_nxt = sda_sample ? STOP : DATA;
      DATA:     if (slot_end && bit_cnt == 3'd7) state_nxt = DATA_ACK;
      DATA_ACK: if (slot_end) state_nxt = STOP;
      STOP:     if (slot_end) state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  // Timebase runs only inside a transaction, so it is back at zero in IDLE.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      div_cnt <= '0;
      quarter <= 2'd0;
      bit_cnt <= 3'd0;
    end else if (state != IDLE) begin
      div_cnt <= quarter_end ? '0 : div_cnt + DIV_W'(1);
      if (quarter_end) quarter <= quarter + 2'd1;
      if (slot_end && (state == ADDR || state == DATA)) bit_cnt <= bit_cnt + 3'd1;
    end
  end

  // NOTE: the request latches are reset along with the control flops; they are
  // only a few bits wide and a defined value keeps the bus outputs X-free.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      armed      <= 1'b0;
      addr_q     <= 7'h00;
      rw_q       <= 1'b0;
      wdata_q    <= 8'h00;
      sda_sample <= 1'b1;
      rdata      <= 8'h00;
      ack_err    <= 1'b0;
      done       <= 1'b0;
    end else begin
      armed <= 1'b1;
      done  <= (state == STOP) && slot_end;
      if (accept) begin
        addr_q  <= addr;
        rw_q    <= rw;
        wdata_q <= wdata;
        ack_err <= 1'b0;
      end
      if (sample_now) begin
        sda_sample <= sda_in;
        if (state == DATA && rw_q) rdata <= {rdata[6:0], sda_in};
      end
      if (slot_end && sda_sample &&
          (state == ADDR_ACK || (state == DATA_ACK && !rw_q)))
        ack_err <= 1'b1;
    end
  end

  // NOTE: defaults first so every path assigns every output and no latch forms.
  always_comb begin
    scl_out = 1'b1;
    sda_out = 1'b1;
    sda_oe  = 1'b0;
    unique case (state)
      START: begin
        sda_oe  = 1'b1;
        sda_out = ~quarter[1];
      end
      ADDR: begin
        scl_out = quarter[1];
        sda_oe  = 1'b1;
        sda_out = addr_byte[~bit_cnt];
      end
      ADDR_ACK: scl_out = quarter[1];
      DATA: begin
        scl_out = quarter[1];
        sda_oe  = ~rw_q;
        sda_out = rw_q | wdata_q[~bit_cnt];
      end
      DATA_ACK: begin
        // a read ends with the master NACKing the byte
        scl_out = quarter[1];
        sda_oe  = rw_q;
      end
      STOP: begin
        scl_out = quarter[1];
        sda_oe  = (quarter != 2'd3);
        sda_out = (quarter == 2'd3);
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_i2c_master_byte.sv
// Bench for i2c_master_byte: two instances (CLK_DIV=4 and 1) on open-drain
// buses with a behavioural slave each, and a queue of expected completions.
module tb_i2c_master_byte;

  logic       clk = 1'b0;
  logic       rst_;
  logic       start_v[2], rw_v[2], sda_in_v[2];
  logic       busy_v[2], done_v[2], ack_err_v[2], scl_v[2], sout_v[2], soe_v[2];
  logic [6:0] addr_v[2];
  logic [7:0] wdata_v[2], rdata_v[2];

  always #5 clk = ~clk;

  i2c_master_byte #(.CLK_DIV(4)) dut0 (
    .clk(clk), .rst_(rst_), .start(start_v[0]), .rw(rw_v[0]), .addr(addr_v[0]),
    .wdata(wdata_v[0]), .sda_in(sda_in_v[0]), .busy(busy_v[0]), .done(done_v[0]),
    .ack_err(ack_err_v[0]), .rdata(rdata_v[0]), .scl_out(scl_v[0]),
    .sda_out(sout_v[0]), .sda_oe(soe_v[0]));

  i2c_master_byte #(.CLK_DIV(1)) dut1 (
    .clk(clk), .rst_(rst_), .start(start_v[1]), .rw(rw_v[1]), .addr(addr_v[1]),
    .wdata(wdata_v[1]), .sda_in(sda_in_v[1]), .busy(busy_v[1]), .done(done_v[1]),
    .ack_err(ack_err_v[1]), .rdata(rdata_v[1]), .scl_out(scl_v[1]),
    .sda_out(sout_v[1]), .sda_oe(soe_v[1]));

  // Slave state (written only by the slave process) and its configuration.
  logic       drv[2], prev_scl[2], prev_line[2], ack18_oe[2], ack18_out[2];
  logic [7:0] addr_seen[2], data_seen[2];
  int         rises[2], last_rise[2], min_per[2], max_per[2], done_cnt[2];
  logic       cfg_ack_addr[2], cfg_ack_data[2];
  logic [7:0] cfg_rbyte[2];
  int         cyc = 0;

  // open-drain line: low if either side pulls it low
  assign sda_in_v[0] = (soe_v[0] ? sout_v[0] : 1'b1) & drv[0];
  assign sda_in_v[1] = (soe_v[1] ? sout_v[1] : 1'b1) & drv[1];

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    for (int b = 0; b < 2; b++) begin
      drv[b] = 1'b1; prev_scl[b] = 1'b1; prev_line[b] = 1'b1; rises[b] = 0;
      done_cnt[b] = 0; last_rise[b] = -1; min_per[b] = 0; max_per[b] = 0;
      addr_seen[b] = 8'h00; data_seen[b] = 8'h00; ack18_oe[b] = 1'b0; ack18_out[b] = 1'b0;
    end
  end

  always @(negedge clk) begin
    for (int b = 0; b < 2; b++) begin
      logic ln;
      int   n;
      ln = sda_in_v[b];
      if (done_v[b]) done_cnt[b] = done_cnt[b] + 1;
      if (!rst_) begin
        drv[b] = 1'b1; prev_scl[b] = 1'b1; prev_line[b] = 1'b1; rises[b] = 0;
      end else begin
        if (prev_scl[b] && scl_v[b] && prev_line[b] && !ln) begin
          rises[b] = 0; last_rise[b] = -1; min_per[b] = 100000; max_per[b] = 0;
          addr_seen[b] = 8'h00; data_seen[b] = 8'h00; ack18_oe[b] = 1'b0; ack18_out[b] = 1'b0;
        end else if (!prev_scl[b] && scl_v[b]) begin
          rises[b] = rises[b] + 1;
          n = rises[b];
          if (n <= 8) addr_seen[b] = {addr_seen[b][6:0], ln};
          else if (n >= 10 && n <= 17) data_seen[b] = {data_seen[b][6:0], ln};
          else if (n == 18) begin ack18_oe[b] = soe_v[b]; ack18_out[b] = sout_v[b]; end
          if (last_rise[b] >= 0) begin
            if (cyc - last_rise[b] < min_per[b]) min_per[b] = cyc - last_rise[b];
            if (cyc - last_rise[b] > max_per[b]) max_per[b] = cyc - last_rise[b];
          end
          last_rise[b] = cyc;
        end else if (prev_scl[b] && !scl_v[b]) begin
          n = rises[b] + 1;
          if (n == 9) drv[b] = !cfg_ack_addr[b];
          else if (n >= 10 && n <= 17 && addr_seen[b][0] && cfg_ack_addr[b])
            drv[b] = cfg_rbyte[b][17-n];
          else if (n == 18 && !addr_seen[b][0]) drv[b] = !cfg_ack_data[b];
          else drv[b] = 1'b1;
        end
        prev_scl[b]  = scl_v[b];
        prev_line[b] = ln;
      end
    end
  end

  typedef struct {
    int         b;
    logic [6:0] addr;
    logic       rw;
    logic [7:0] wdata;
    logic       ack_addr;
    logic       ack_data;
    logic [7:0] rbyte;
    int         exp_lat;
    logic       exp_err;
    logic [7:0] exp_rdata;
  } vec_t;

  typedef struct {
    int         b;
    int         t0;
    int         lat;
    logic       err;
    logic [7:0] rdata;
    logic [7:0] abyte;
    logic [7:0] dbyte;
    logic       chk_data;
    int         rises;
    logic       rd;
  } exp_t;

  exp_t sb[$];
  vec_t tbl[9];
  int   checks = 0;
  int   failures = 0;
  int   exp_done[2];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Called at a negedge; start is sampled by the following rising edge.
  task automatic drive_txn(input vec_t v);
    exp_t e;
    cfg_ack_addr[v.b] = v.ack_addr;
    cfg_ack_data[v.b] = v.ack_data;
    cfg_rbyte[v.b]    = v.rbyte;
    addr_v[v.b]  = v.addr;
    rw_v[v.b]    = v.rw;
    wdata_v[v.b] = v.wdata;
    start_v[v.b] = 1'b1;
    e.b = v.b; e.t0 = cyc + 1; e.lat = v.exp_lat; e.err = v.exp_err;
    e.rdata = v.exp_rdata; e.abyte = {v.addr, v.rw};
    e.dbyte = v.rw ? v.rbyte : v.wdata; e.chk_data = v.ack_addr;
    e.rises = v.ack_addr ? 19 : 10; e.rd = v.rw && v.ack_addr;
    sb.push_back(e);
    @(negedge clk);
    start_v[v.b] = 1'b0;
  endtask

  task automatic wait_done(input int b);
    exp_t e;
    int   n = 0;
    int   per = (b == 0) ? 16 : 4;
    while (!done_v[b] && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() == 0) begin
      check("sb_nonempty", 0, 1);
      return;
    end
    e = sb.pop_front();
    check("done_seen", done_v[b], 1);
    if (!done_v[b]) return;
    exp_done[b]++;
    check("dut_sel", b, e.b);
    check("latency", cyc - e.t0, e.lat);
    check("busy_at_done", busy_v[b], 0);
    check("ack_err", ack_err_v[b], e.err);
    check("rdata", rdata_v[b], e.rdata);
    check("addr_bits", addr_seen[b], e.abyte);
    check("scl_rises", rises[b], e.rises);
    check("scl_period_min", min_per[b], per);
    check("scl_period_max", max_per[b], per);
    if (e.chk_data) check("data_bits", data_seen[b], e.dbyte);
    if (e.rd) begin
      check("rd_ack_oe", ack18_oe[b], 1);
      check("rd_ack_out", ack18_out[b], 1);
    end
  endtask

  initial begin
    vec_t v;
    exp_done[0] = 0; exp_done[1] = 0;
    for (int b = 0; b < 2; b++) begin
      start_v[b] = 1'b0; rw_v[b] = 1'b0; addr_v[b] = 7'h00; wdata_v[b] = 8'h00;
      cfg_ack_addr[b] = 1'b1; cfg_ack_data[b] = 1'b1; cfg_rbyte[b] = 8'h00;
    end
    //          b  addr   rw    wdata  ackA  ackD  rbyte  lat  err   rdata
    tbl[0] = '{0, 7'h5A, 1'b0, 8'hA5, 1'b1, 1'b1, 8'h00, 320, 1'b0, 8'h00};
    tbl[1] = '{0, 7'h5A, 1'b1, 8'h00, 1'b1, 1'b1, 8'h3C, 320, 1'b0, 8'h3C};
    tbl[2] = '{0, 7'h5A, 1'b0, 8'h00, 1'b0, 1'b1, 8'h00, 176, 1'b1, 8'h3C};
    tbl[3] = '{0, 7'h5A, 1'b1, 8'h00, 1'b0, 1'b1, 8'h99, 176, 1'b1, 8'h3C};
    tbl[4] = '{0, 7'h33, 1'b0, 8'h5A, 1'b1, 1'b0, 8'h00, 320, 1'b1, 8'h3C};
    tbl[5] = '{1, 7'h12, 1'b0, 8'hFF, 1'b1, 1'b1, 8'h00,  80, 1'b0, 8'h00};
    tbl[6] = '{1, 7'h7F, 1'b1, 8'h00, 1'b1, 1'b1, 8'h81,  80, 1'b0, 8'h81};
    tbl[7] = '{1, 7'h01, 1'b0, 8'h00, 1'b0, 1'b1, 8'h00,  44, 1'b1, 8'h81};
    tbl[8] = '{0, 7'h6C, 1'b1, 8'hFF, 1'b1, 1'b1, 8'hC3, 320, 1'b0, 8'hC3};

    rst_ = 1'b1;
    #1 rst_ = 1'b0;
    #1;
    check("rst_busy", busy_v[0], 0);
    check("rst_done", done_v[0], 0);
    check("rst_ack_err", ack_err_v[0], 0);
    check("rst_rdata", rdata_v[0], 8'h00);
    check("rst_scl", scl_v[0], 1);
    check("rst_sda_out", sout_v[0], 1);
    check("rst_sda_oe", soe_v[0], 0);
    check("rst_scl_div1", scl_v[1], 1);

    // start raised together with reset release must be ignored
    repeat (3) @(negedge clk);
    addr_v[0] = 7'h5A;
    start_v[0] = 1'b1;
    rst_ = 1'b1;
    @(negedge clk);
    check("start_at_release_busy", busy_v[0], 0);
    start_v[0] = 1'b0;
    @(negedge clk);
    check("start_at_release_busy2", busy_v[0], 0);

    for (int i = 0; i < 9; i++) begin
      drive_txn(tbl[i]);
      wait_done(tbl[i].b);
      @(negedge clk);
      @(negedge clk);
      check("done_count", done_cnt[tbl[i].b], exp_done[tbl[i].b]);
    end

    // start during a busy transaction is dropped; start in the done cycle is taken
    v = '{0, 7'h5A, 1'b0, 8'hA5, 1'b1, 1'b1, 8'h00, 320, 1'b0, 8'hC3};
    drive_txn(v);
    repeat (48) @(negedge clk);
    addr_v[0] = 7'h11;
    start_v[0] = 1'b1;
    @(negedge clk);
    start_v[0] = 1'b0;
    check("busy_mid_txn", busy_v[0], 1);
    wait_done(0);
    v = '{0, 7'h2A, 1'b1, 8'h00, 1'b1, 1'b1, 8'h5E, 320, 1'b0, 8'h5E};
    drive_txn(v);
    wait_done(0);
    repeat (400) @(negedge clk);
    check("no_queued_start", done_cnt[0], exp_done[0]);
    check("idle_after_b2b", busy_v[0], 0);

    // reset mid-write: outputs return to reset values, no done
    v = '{0, 7'h5A, 1'b0, 8'h96, 1'b1, 1'b1, 8'h00, 320, 1'b0, 8'h00};
    drive_txn(v);
    repeat (99) @(negedge clk);
    rst_ = 1'b0;
    #1;
    void'(sb.pop_back());
    check("midrst_scl", scl_v[0], 1);
    check("midrst_sda_oe", soe_v[0], 0);
    check("midrst_sda_out", sout_v[0], 1);
    check("midrst_busy", busy_v[0], 0);
    check("midrst_done", done_v[0], 0);
    check("midrst_rdata", rdata_v[0], 8'h00);
    repeat (3) @(negedge clk);
    rst_ = 1'b1;
    repeat (3) @(negedge clk);
    check("midrst_no_done", done_cnt[0], exp_done[0]);
    drive_txn(v);
    wait_done(0);
    @(negedge clk);
    v = '{1, 7'h40, 1'b0, 8'hFF, 1'b1, 1'b1, 8'h00, 80, 1'b0, 8'h00};
    drive_txn(v);
    wait_done(1);
    repeat (2) @(negedge clk);
    check("final_done_count0", done_cnt[0], exp_done[0]);
    check("final_done_count1", done_cnt[1], exp_done[1]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/i2c_master_byte.md
# i2c_master_byte

Single-master I2C bus controller that generates SCL from the system clock and performs one complete transaction per request: START, 7-bit address plus R/W, address ACK, one data byte, data ACK and STOP. It is the stage directly upstream of the slave FSM on the bus: it drives `scl_out` and the SDA line that the slave consumes, and samples SDA when the slave drives it. Host logic issues requests through a start/busy/done handshake.

## Interface
- `CLK_DIV`, default 4: clk cycles per SCL quarter-period; minimum 1. One bit slot is 4 quarters.
- `clk` input 1: system clock; all logic is on the rising edge.
- `rst_` input 1: asynchronous, active-low reset.
- `start` input 1: transaction request; sampled only in IDLE.
- `rw` input 1: 1 = master reads a byte from the slave; 0 = master writes.
- `addr` input 7: slave address.
- `wdata` input 8: byte to write; ignored when `rw`=1.
- `sda_in` input 1: sampled SDA line.
- `busy` output 1: transaction in progress.
- `done` output 1: one-cycle pulse when a transaction completes.
- `ack_err` output 1: 1 if the last transaction saw a NACK from the slave. Valid from `done` until the next accept.
- `rdata` output 8: byte read, MSB first; valid from `done` (read transactions only).
- `scl_out` output 1: SCL.
- `sda_out` output 1: SDA drive value.
- `sda_oe` output 1: 1 = master drives SDA; 0 = released (line pulled high).

## Operation
- Reset values: `busy`=0, `done`=0, `ack_err`=0, `rdata`=8'h00, `scl_out`=1, `sda_out`=1, `sda_oe`=0, state IDLE, all counters 0.
- Accept: `start`=1 in IDLE latches `addr`, `rw` and `wdata`, clears `ack_err`, and moves to START. A `start` pulse while `busy`=1 is ignored, not queued.
- States: IDLE → START → ADDR (8 slots) → ADDR_ACK → DATA (8 slots) → DATA_ACK → STOP → IDLE.
- START slot:
  - q0–q1: SCL=1, SDA driven 1.
  - q2–q3: SCL=1, SDA driven 0.
- Bit slot (ADDR, DATA, ACK):
  - q0–q1: SCL=0. SDA updates at the start of q0.
  - q2–q3: SCL=1.
  - `sda_in` is sampled on the last clk of q2.
- ADDR: shifts out {addr, rw}, MSB first, with `sda_oe`=1.
- ADDR_ACK: `sda_oe`=0. If the sampled value is 1 (NACK), set `ack_err`=1 and go directly to STOP, skipping DATA and DATA_ACK.
- DATA, write (`rw`=0): shift `wdata` out MSB first. In DATA_ACK, `sda_oe`=0; a sampled 1 sets `ack_err`=1. Go to STOP either way.
- DATA, read (`rw`=1): `sda_oe`=0; shift the sampled bits into `rdata`, MSB first. In DATA_ACK, master drives SDA=1 (NACK), ending the read.
- STOP slot:
  - q0–q2: SDA driven 0.
  - q0–q1: SCL=0.
  - q2–q3: SCL=1.
  - q3: SDA released (`sda_oe`=0).
  - On completion, go to IDLE and pulse `done`.
- Counters:
  - Quarter-cycle divider: width ceil(log2(CLK_DIV)), minimum 1 bit.
  - 2-bit quarter index.
  - 3-bit bit counter; wraps 7→0 on leaving ADDR or DATA.
- `rdata` changes only during a read transaction. It retains its value across writes and NACKed transactions.

## Timing
- Acceptance edge is E0. `busy`=1 from E0 until the edge where `done` rises; `busy` falls in the same cycle that `done`=1.
- Slot length is 4·CLK_DIV clk cycles.
- Full transaction is 20 slots. `done` is high in the cycle after edge E0 + 80·CLK_DIV (320 cycles at the default).
- Address NACK transaction is 11 slots: `done` after E0 + 44·CLK_DIV.
- A new `start` can be accepted in the cycle after `done`.
- `rst_` asserted mid-transaction: all outputs return to reset values immediately (asynchronous). No STOP is generated. `done` does not pulse.
- `start` and `rst_` deasserting in the same cycle: `start` is ignored.

## Test plan
- Write, CLK_DIV=4: `addr`=7'h5A, `rw`=0, `wdata`=8'hA5; model slave ACKs both.
  - SDA bits in ADDR slots: 1,0,1,1,0,1,0,0; in DATA slots: 1,0,1,0,0,1,0,1.
  - `done` at 320 cycles after accept; `ack_err`=0.
- Read, CLK_DIV=4: `addr`=7'h5A, `rw`=1; slave ACKs and drives 8'h3C.
  - `rdata`=8'h3C at `done`.
  - `sda_oe`=1, `sda_out`=1 during DATA_ACK; `ack_err`=0.
- Address NACK: slave leaves SDA high.
  - `ack_err`=1; no DATA slots; STOP follows ADDR_ACK.
  - `done` at 176 cycles; `rdata` unchanged.
- `start` pulsed at cycle 50 of an active transaction: ignored, single `done` only. `start` in the cycle after `done`: accepted.
- `rst_` pulled low at cycle 100 of a write: immediately `scl_out`=1, `sda_oe`=0, `busy`=0, no `done`. Next transaction completes normally.
- CLK_DIV=1, write 8'hFF with slave ACKs: `scl_out` period is 4 cycles; `done` at 80 cycles.
